// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks: active-low hex glyph table
// and the "everything dark" patterns for anodes and segments.
package seg7_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Entry n is the glyph for hex digit n, {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] digit_anode_n(input digit_idx_t idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble -> active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = HEX_SEG_TABLE[nibble][6:0];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed 7-segment scanner with per-frame input snapshot,
// per-digit decimal point and per-digit blinking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  LE_in,
    input  logic        blank,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;
    logic [31:0]   num_sh_q, num_sh_d;
    logic [7:0]    point_sh_q, point_sh_d;
    logic [7:0]    le_sh_q, le_sh_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          ft_q, ft_d;

    logic          slot_tick;
    logic          boundary;
    logic [3:0]    cur_nibble;
    logic [6:0]    hex_seg_n;

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg_n  (hex_seg_n)
    );

    always_comb begin
        slot_tick = (cnt_q == CNT_LAST);
        boundary  = slot_tick && (idx_q == 3'd7);

        cnt_d = slot_tick ? '0 : cnt_q + CW'(1);
        idx_d = slot_tick ? idx_q + 3'd1 : idx_q;

        num_sh_d   = num_sh_q;
        point_sh_d = point_sh_q;
        le_sh_d    = le_sh_q;
        frm_d      = frm_q;
        phase_d    = phase_q;
        if (boundary) begin
            num_sh_d   = Disp_num;
            point_sh_d = point_in;
            le_sh_d    = LE_in;
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end

        ft_d = boundary;

        // Output stage looks at the current index/shadow, so it trails them by one clock.
        cur_nibble = num_sh_q[{idx_q, 2'b00} +: 4];
        an_d       = blank ? AN_OFF : digit_anode_n(idx_q);
        seg_d      = {~point_sh_q[idx_q], hex_seg_n};
        if (blank || (le_sh_q[idx_q] && phase_q)) begin
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            frm_q      <= '0;
            phase_q    <= 1'b0;
            num_sh_q   <= '0;
            point_sh_q <= '0;
            le_sh_q    <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            ft_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frm_q      <= frm_d;
            phase_q    <= phase_d;
            num_sh_q   <= num_sh_d;
            point_sh_q <= point_sh_d;
            le_sh_q    <= le_sh_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            ft_q       <= ft_d;
        end
    end

    assign AN         = an_q;
    assign SEGMENT    = seg_q;
    assign frame_tick = ft_q;

endmodule
